out_channel_checker: RTL and testbench
======================================

OUT_CHANNEL_CHECKER -- requirements
Module: out_channel_checker

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12: width of every out-channel word.
REQ-002 SHALL have parameter NOut, default 2: number of expected output words.
REQ-003 SHALL have parameter Expected, default {12'd1,12'd2}: packed NOut*MemoryElementWidth expected words, with word 0 in the LSBs.
REQ-004 SHALL have parameter FifoDepth, default 4: decoupling buffer depth, a power of two and at least 2.
REQ-005 SHALL have parameter MaxSteps, default 8: program step budget.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 SHALL have port clock, input, 1: driving clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high restart.
REQ-009 SHALL have port in_valid, input, 1: producer offers in_data.
REQ-010 SHALL have port in_data, input, MemoryElementWidth: out-channel word from the program engine.
REQ-011 SHALL have port in_ready, output, 1: checker accepts the word this cycle.
REQ-012 SHALL have port step, input, 1: pulses once per executed program instruction.
REQ-013 SHALL have port finished, output, 1: goes high when checking is complete.
REQ-014 SHALL have port success, output, 1: valid when finished is high; 1 means all expected words matched.
REQ-015 SHALL have port status, output, 2: result code (0 busy, 1 pass, 2 mismatch, 3 count error).
REQ-016 SHALL have port received, output, $clog2(NOut+1): number of words compared so far.

Function
REQ-017 SHALL implement a two-state FSM, RUN then DONE; DONE is left only by reset.
REQ-018 SHALL drive in_ready = (state==RUN) && !fifo_full; the handshake completes on in_valid && in_ready.
REQ-019 SHALL keep in_ready low when the FIFO is full, even in a cycle that pops.
REQ-020 SHALL write an accepted word into the FIFO at the clock edge; it is compared no earlier than the next cycle (1-cycle minimum latency).
REQ-021 SHALL, in RUN with the FIFO non-empty, pop one word per cycle and compare it with Expected[received].
REQ-022 SHALL increment received on a matching pop.
REQ-023 SHALL, on a mismatch, enter DONE with status=2 and success=0; received is not incremented.
REQ-024 SHALL, on a pop when received==NOut (surplus word), enter DONE with status=3 and success=0.
REQ-025 SHALL count step pulses in RUN, saturating at MaxSteps+1.
REQ-026 SHALL time out when the step count becomes greater than MaxSteps and enter DONE.
REQ-027 SHALL, on timeout, set status=1 and success=1 if received==NOut and the FIFO is empty after this cycle's pop; otherwise status=3 and success=0.
REQ-028 SHALL give a mismatch or surplus in the same cycle as the timeout priority over the timeout result.
REQ-029 SHALL assert finished=1 in DONE and hold finished, success, status and received stable until reset.
REQ-030 SHALL, in DONE, ignore step and in_valid.
REQ-031 SHALL implement the FIFO pointers as wrapping log2(FifoDepth)-bit pointers plus a count, so full and empty are unambiguous.

Reset
REQ-032 SHALL, while reset is high at a clock edge, set state=RUN, empty the FIFO, and clear received, the step count, finished, success and status to 0.
REQ-033 SHALL give reset priority over every other event, including mid-operation and in DONE.
REQ-034 SHALL hold in_ready low in any cycle in which reset is high.

Structure
REQ-035 SHALL place the state enum, the status codes (STATUS_BUSY/PASS/MISMATCH/COUNT) and the default MemoryElementWidth in the shared package fpga_pkg.
REQ-036 SHALL instantiate one sub-module, out_fifo (parameters: width, depth; ports: push, pop, din, dout, full, empty).

Verification
REQ-037 SHALL test pass: words 2 then 1 on consecutive cycles, then 9 step pulses -> finished=1, success=1, status=1, received=2.
REQ-038 SHALL test mismatch: words 2 then 5 -> DONE one cycle after word 5 is popped, status=2, success=0, received=1, before any timeout.
REQ-039 SHALL test short count: only word 2, then 9 steps -> status=3, success=0, received=1.
REQ-040 SHALL test backpressure: FifoDepth=2 with the pop stalled by forcing a mismatch-free burst of 3 words -> in_ready=0 on the 3rd offer, the word is held by the producer, and all words are compared in order.
REQ-041 SHALL test surplus: words 2, 1, 7 -> status=3, success=0, received=2.
REQ-042 SHALL test reset mid-run: reset after word 2 -> finished=0, status=0, received=0, FIFO empty; the subsequent pass sequence succeeds.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared definitions for the out-channel checker: FSM states, result codes
// and the default word width of the program engine's out channel.
package fpga_pkg;

   localparam int MEMORY_ELEMENT_WIDTH = 12;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   localparam logic [1:0] STATUS_BUSY     = 2'd0;
   localparam logic [1:0] STATUS_PASS     = 2'd1;
   localparam logic [1:0] STATUS_MISMATCH = 2'd2;
   localparam logic [1:0] STATUS_COUNT    = 2'd3;

endpackage

// File: rtl/out_fifo.sv
// Small synchronous FIFO decoupling the producer handshake from the compare stage.
// Wrapping pointers plus an occupancy count keep full and empty unambiguous.
module out_fifo
   import fpga_pkg::*;
#(
   parameter int Width = MEMORY_ELEMENT_WIDTH,
   parameter int Depth = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] din,
   output logic [Width-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wr_ptr;
   logic [PtrW-1:0]  r_rd_ptr;
   logic [CntW-1:0]  r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign full      = (r_count == CntW'(Depth));
   assign empty     = (r_count == '0);
   assign dout      = r_mem[r_rd_ptr];

   // Storage array carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CntW'(1);
            2'b01:   r_count <= r_count - CntW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/out_channel_checker.sv
// Compares the program engine's out-channel words against a fixed expected list
// and reports pass, mismatch or count error once a result is known or steps run out.
module out_channel_checker
   import fpga_pkg::*;
#(
   parameter int                                MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
   parameter int                                NOut               = 2,
   parameter logic [NOut*MemoryElementWidth-1:0] Expected          = {12'd1, 12'd2},
   parameter int                                FifoDepth          = 4,
   parameter int                                MaxSteps           = 8
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            in_valid,
   input  logic [MemoryElementWidth-1:0]   in_data,
   output logic                            in_ready,
   input  logic                            step,
   output logic                            finished,
   output logic                            success,
   output logic [1:0]                      status,
   output logic [$clog2(NOut+1)-1:0]       received
);

   localparam int RecW  = $clog2(NOut + 1);
   localparam int StepW = $clog2(MaxSteps + 2);

   state_e                        r_state;
   logic [RecW-1:0]               r_received;
   logic [StepW-1:0]              r_steps;
   logic                          r_finished;
   logic                          r_success;
   logic [1:0]                    r_status;

   logic                          w_in_ready;
   logic                          w_push;
   logic                          w_pop;
   logic                          w_full;
   logic                          w_empty;
   logic [MemoryElementWidth-1:0] w_dout;
   logic [MemoryElementWidth-1:0] w_exp_word;
   logic                          w_surplus;
   logic                          w_mismatch;
   logic                          w_match;
   logic [RecW-1:0]               w_rcv_next;
   logic                          w_timeout;
   logic                          w_empty_after;
   logic                          w_pass_now;

   assign w_in_ready = (r_state == ST_RUN) && !w_full && !reset;
   assign w_push     = in_valid && w_in_ready;
   assign w_pop      = (r_state == ST_RUN) && !w_empty;

   out_fifo #(
      .Width (MemoryElementWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (in_data),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   always_comb begin
      w_exp_word = '0;
      if (r_received < RecW'(NOut)) begin
         w_exp_word = Expected[int'(r_received)*MemoryElementWidth +: MemoryElementWidth];
      end else begin
         w_exp_word = '0;
      end
   end

   assign w_surplus  = w_pop && (r_received == RecW'(NOut));
   assign w_mismatch = w_pop && !w_surplus && (w_dout != w_exp_word);
   assign w_match    = w_pop && !w_surplus && !w_mismatch;
   assign w_rcv_next = r_received + RecW'(w_match);
   assign w_timeout  = step && (r_steps == StepW'(MaxSteps));

   // In RUN every non-empty cycle pops and at most one word arrives per cycle,
   // so the FIFO never holds more than one word: a pop empties it unless a push lands.
   assign w_empty_after = !w_push && (w_empty || w_pop);
   assign w_pass_now    = (w_rcv_next == RecW'(NOut)) && w_empty_after;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_RUN;
         r_received <= '0;
         r_steps    <= '0;
         r_finished <= 1'b0;
         r_success  <= 1'b0;
         r_status   <= STATUS_BUSY;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (step && (r_steps != StepW'(MaxSteps + 1))) begin
                  r_steps <= r_steps + StepW'(1);
               end
               r_received <= w_rcv_next;
               if (w_surplus || w_mismatch) begin
                  r_state    <= ST_DONE;
                  r_finished <= 1'b1;
                  r_success  <= 1'b0;
                  r_status   <= w_surplus ? STATUS_COUNT : STATUS_MISMATCH;
               end else if (w_timeout) begin
                  r_state    <= ST_DONE;
                  r_finished <= 1'b1;
                  r_success  <= w_pass_now;
                  r_status   <= w_pass_now ? STATUS_PASS : STATUS_COUNT;
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign in_ready = w_in_ready;
   assign finished = r_finished;
   assign success  = r_success;
   assign status   = r_status;
   assign received = r_received;

endmodule

// File: tb/tb_out_channel_checker.sv
// Scoreboard bench: each scenario pushes its predicted verdict, monitors compare
// the DUT verdict (and its stability) whenever finished is high.
module tb_out_channel_checker;

   typedef struct {
      int status;
      int success;
      int received;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1 = 1'b1, v1 = 1'b0, st1 = 1'b0;
   logic [11:0] d1 = '0;
   logic        rdy1, fin1, suc1;
   logic [1:0]  sta1, rcv1;

   logic        rst2 = 1'b1, v2 = 1'b0, st2 = 1'b0;
   logic [11:0] d2 = '0;
   logic        rdy2, fin2, suc2;
   logic [1:0]  sta2, rcv2;

   out_channel_checker dut1 (
      .clock(clk), .reset(rst1), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
      .step(st1), .finished(fin1), .success(suc1), .status(sta1), .received(rcv1));

   out_channel_checker #(.NOut(3), .Expected({12'd3, 12'd1, 12'd2}), .FifoDepth(2)) dut2 (
      .clock(clk), .reset(rst2), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
      .step(st2), .finished(fin2), .success(suc2), .status(sta2), .received(rcv2));

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q1[$];
   exp_t q2[$];
   int   ex1[$] = '{2, 1};
   int   ex2[$] = '{2, 1, 3};

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference verdict from the word list alone, assuming all words drain before the step budget expires.
   function automatic exp_t predict(input int ws[$], input int ex[$]);
      exp_t r;
      r.status = 1; r.success = 1; r.received = 0;
      for (int i = 0; i < ws.size(); i++) begin
         if (i >= ex.size()) begin r.status = 3; r.success = 0; return r; end
         if (ws[i] != ex[i]) begin r.status = 2; r.success = 0; return r; end
         r.received = i + 1;
      end
      if (r.received != ex.size()) begin r.status = 3; r.success = 0; end
      return r;
   endfunction

   exp_t cur1, cur2;
   bit   fq1 = 0, fq2 = 0, have1 = 0, have2 = 0;

   always @(negedge clk) begin
      if (rst1) begin
         fq1 = 0; have1 = 0;
      end else begin
         if (fin1 && !fq1) begin
            if (q1.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_finish1 actual=1 required=0");
               have1 = 0;
            end else begin
               cur1 = q1.pop_front(); have1 = 1;
            end
         end
         if (fin1 && have1) begin
            chk("status1", int'(sta1), cur1.status);
            chk("success1", int'(suc1), cur1.success);
            chk("received1", int'(rcv1), cur1.received);
         end
         fq1 = fin1;
      end
   end

   always @(negedge clk) begin
      if (rst2) begin
         fq2 = 0; have2 = 0;
      end else begin
         if (fin2 && !fq2) begin
            if (q2.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_finish2 actual=1 required=0");
               have2 = 0;
            end else begin
               cur2 = q2.pop_front(); have2 = 1;
            end
         end
         if (fin2 && have2) begin
            chk("status2", int'(sta2), cur2.status);
            chk("success2", int'(suc2), cur2.success);
            chk("received2", int'(rcv2), cur2.received);
         end
         fq2 = fin2;
      end
   end

   // res: 0 accepted, 1 producer stopped because the checker finished, 2 timed out
   task automatic send1(input int w, output int res);
      res = 2;
      @(negedge clk);
      v1 = 1'b1; d1 = 12'(w);
      for (int k = 0; k < 20; k++) begin
         #1;
         if (fin1) begin res = 1; break; end
         if (rdy1) begin res = 0; @(posedge clk); break; end
         @(negedge clk);
      end
      if (res == 2) begin
         n_errors++;
         $display("FAIL handshake_timeout actual=no_accept required=accept word=%0d", w);
      end
   endtask

   task automatic drop1();
      @(negedge clk);
      v1 = 1'b0;
   endtask

   task automatic steps1(input int n);
      repeat (n) begin @(negedge clk); st1 = 1'b1; end
      @(negedge clk);
      st1 = 1'b0;
   endtask

   task automatic wait_fin1(input string name);
      bit seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (fin1) begin seen = 1; break; end
      end
      chk(name, int'(seen), 1);
      @(negedge clk);
   endtask

   task automatic reset1();
      @(negedge clk);
      rst1 = 1'b1; v1 = 1'b0; st1 = 1'b0;
      #1 chk("ready_in_reset1", int'(rdy1), 0);
      @(negedge clk);
      chk("reset_finished1", int'(fin1), 0);
      chk("reset_status1", int'(sta1), 0);
      chk("reset_received1", int'(rcv1), 0);
      rst1 = 1'b0;
   endtask

   task automatic run1(input int ws[$], input bit gaps, input string name);
      int res;
      q1.push_back(predict(ws, ex1));
      for (int i = 0; i < ws.size(); i++) begin
         n_checks++;
         send1(ws[i], res);
         if (res != 0) break;
         if (gaps && ($urandom_range(0, 1) == 1)) begin
            drop1();
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      drop1();
      repeat (3) @(negedge clk);
      steps1(9);
      wait_fin1(name);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int ws[$];
      int res;
      repeat (2) @(negedge clk);
      #1;
      chk("init_ready1", int'(rdy1), 0);
      chk("init_finished1", int'(fin1), 0);
      chk("init_success1", int'(suc1), 0);
      chk("init_status1", int'(sta1), 0);
      chk("init_received1", int'(rcv1), 0);
      @(negedge clk);
      rst1 = 1'b0; rst2 = 1'b0;
      #1 chk("ready_after_reset1", int'(rdy1), 1);

      ws = '{2, 1};    run1(ws, 0, "pass_done");
      reset1();

      q1.push_back(predict('{2, 5}, ex1));
      send1(2, res);
      send1(5, res);
      @(negedge clk); v1 = 1'b0;
      chk("mismatch_not_yet_done", int'(fin1), 0);
      @(negedge clk);
      chk("mismatch_done_next_cycle", int'(fin1), 1);
      wait_fin1("mismatch_done");
      reset1();

      ws = '{2};       run1(ws, 0, "short_done");
      reset1();
      ws = '{2, 1, 7}; run1(ws, 0, "surplus_done");
      reset1();

      send1(2, res);
      drop1();
      @(negedge clk);
      chk("midrun_received_before", int'(rcv1), 1);
      rst1 = 1'b1;
      #1 chk("midrun_ready_in_reset", int'(rdy1), 0);
      @(negedge clk);
      chk("midrun_finished", int'(fin1), 0);
      chk("midrun_status", int'(sta1), 0);
      chk("midrun_received", int'(rcv1), 0);
      chk("midrun_fifo_empty", int'(dut1.w_empty), 1);
      rst1 = 1'b0;
      ws = '{2, 1};    run1(ws, 0, "midrun_pass_done");

      for (int t = 0; t < 25; t++) begin
         int len;
         reset1();
         ws = {};
         len = $urandom_range(0, 3);
         for (int i = 0; i < len; i++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r < 2)       ws.push_back((i < 2) ? ex1[i] : $urandom_range(1, 2));
            else if (r == 2) ws.push_back((i < 2) ? ex1[1 - i] : 2);
            else             ws.push_back($urandom_range(0, 4095));
         end
         run1(ws, 1, "random_done");
      end

      // Backpressure: stall the compare stage so the depth-2 FIFO fills.
      q2.push_back(predict(ex2, ex2));
      @(negedge clk);
      force dut2.w_pop = 1'b0;
      v2 = 1'b1; d2 = 12'd2;
      #1 chk("bp_ready_1st", int'(rdy2), 1);
      @(negedge clk);
      d2 = 12'd1;
      #1 chk("bp_ready_2nd", int'(rdy2), 1);
      @(negedge clk);
      d2 = 12'd3;
      #1 chk("bp_ready_3rd", int'(rdy2), 0);
      @(negedge clk);
      #1 chk("bp_ready_held", int'(rdy2), 0);
      release dut2.w_pop;
      #1 chk("bp_ready_popping_full", int'(rdy2), 0);
      @(negedge clk);
      #1 chk("bp_ready_after_pop", int'(rdy2), 1);
      chk("bp_received_first", int'(rcv2), 1);
      @(negedge clk);
      v2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("bp_received_all", int'(rcv2), 3);
      repeat (9) begin @(negedge clk); st2 = 1'b1; end
      @(negedge clk);
      st2 = 1'b0;
      begin
         bit seen = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (fin2) begin seen = 1; break; end
         end
         chk("bp_done", int'(seen), 1);
      end
      @(negedge clk);

      chk("scoreboard1_drained", q1.size(), 0);
      chk("scoreboard2_drained", q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
